mem_arbiter: RTL and testbench

- Responder end of the cache-to-memory request protocol.
- Accepts instruction-fetch requests (iREN/iaddr) and data requests (dREN/dWEN/daddr/dstore) from up to CPUS cache pairs.
- Arbitrates them onto a single variable-latency RAM port and returns iwait/iload and dwait/dload per port.
- Sits between the per-CPU icache/dcache blocks and the RAM model.

---
 rtl/cpu_types_pkg.sv | 29 ++
 rtl/mem_arbiter_if.sv | 38 +++
 rtl/mem_arbiter_rr_picker.sv | 37 +++
 rtl/mem_arbiter.sv | 177 +++++++++++++++++
 tb/tb_mem_arbiter.sv | 297 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_types_pkg.sv
// Shared CPU/memory types.
// Provides the bus word type, the RAM handshake state reported by the RAM model,
// and the memory arbiter's FSM state and transaction kind encodings.
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  // Status reported by the RAM model on every cycle.
  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

  // Arbiter FSM states, kept as plain constants so older code can compare raw bits.
  typedef logic [1:0] arb_state_t;
  localparam arb_state_t IDLE = 2'd0;
  localparam arb_state_t REQ  = 2'd1;
  localparam arb_state_t RESP = 2'd2;

  // Kind of the transaction currently owned by the arbiter.
  typedef enum logic [1:0] {
    IREAD  = 2'd0,
    DREAD  = 2'd1,
    DWRITE = 2'd2
  } arb_kind_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// Bus bundle between the per-CPU caches, the memory arbiter and the RAM model.
// Cache side : iREN/iaddr -> iwait/iload, dREN/dWEN/daddr/dstore -> dwait/dload.
// RAM side   : ramREN/ramWEN/ramaddr/ramstore -> ramload/ramstate.
// modport slave  : the arbiter's view (responds to caches, drives the RAM).
// modport master : the environment's view (caches + RAM model).
interface mem_arbiter_if #(parameter int CPUS = 2);
  import cpu_types_pkg::*;

  logic [CPUS-1:0]  iREN;
  word_t [CPUS-1:0] iaddr;
  logic [CPUS-1:0]  iwait;
  word_t [CPUS-1:0] iload;

  logic [CPUS-1:0]  dREN;
  logic [CPUS-1:0]  dWEN;
  word_t [CPUS-1:0] daddr;
  word_t [CPUS-1:0] dstore;
  logic [CPUS-1:0]  dwait;
  word_t [CPUS-1:0] dload;

  logic      ramREN;
  logic      ramWEN;
  word_t     ramaddr;
  word_t     ramstore;
  word_t     ramload;
  ramstate_t ramstate;

  modport slave (
    input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
    output iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore
  );

  modport master (
    output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
    input  iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore
  );

endinterface

// File: rtl/mem_arbiter_rr_picker.sv
// Round-robin picker: combinational priority-rotate over an N-wide request vector.
// i_req : request per requester      i_ptr : index holding highest priority
// o_gnt : one-hot grant              o_idx : index of the grant
// o_any : at least one request present
module rr_picker #(
  parameter int N  = 2,
  parameter int IW = 1
) (
  input  logic [N-1:0]  i_req,
  input  logic [IW-1:0] i_ptr,
  output logic [N-1:0]  o_gnt,
  output logic [IW-1:0] o_idx,
  output logic          o_any
);

  int   w_dist;
  int   w_best;
  logic w_hit;

  // Choose the requester at the smallest upward distance from i_ptr (with wrap).
  always_comb begin
    w_best = N;
    w_dist = 0;
    w_hit  = 1'b0;
    o_idx  = '0;
    o_any  = 1'b0;
    for (int j = 0; j < N; j++) begin
      w_dist = (j >= int'(i_ptr)) ? (j - int'(i_ptr)) : (j + N - int'(i_ptr));
      w_hit  = i_req[j] && (w_dist < w_best);
      w_best = w_hit ? w_dist : w_best;
      o_idx  = w_hit ? IW'(j) : o_idx;
      o_any  = o_any | i_req[j];
    end
    o_gnt = o_any ? (N'(1'b1) << o_idx) : {N{1'b0}};
  end

endmodule

// File: rtl/mem_arbiter.sv
// Memory arbiter: responder end of the cache-to-memory request protocol.
// Serves instruction and data requests from CPUS cache pairs onto one RAM port,
// one access at a time. Data requests beat instruction requests; each class is
// round-robin from rr_ptr. All outputs are registered.
// Ports: CLK (rising edge), nRST (synchronous, active-low), bus (slave modport
// carrying the cache request/response signals and the RAM port).
module mem_arbiter
  import cpu_types_pkg::*;
#(
  parameter int CPUS = 2
) (
  input logic          CLK,
  input logic          nRST,
  mem_arbiter_if.slave bus
);

  localparam int IW = (CPUS > 1) ? $clog2(CPUS) : 1;

  arb_state_t       r_state;
  arb_kind_t        r_kind;
  logic [IW-1:0]    r_port;
  logic [CPUS-1:0]  r_gnt;
  logic [IW-1:0]    r_rr_ptr;
  logic             r_hold;
  word_t            r_data;
  logic [CPUS-1:0]  r_iwait;
  logic [CPUS-1:0]  r_dwait;
  word_t [CPUS-1:0] r_iload;
  word_t [CPUS-1:0] r_dload;
  logic             r_ramREN;
  logic             r_ramWEN;
  word_t            r_ramaddr;
  word_t            r_ramstore;

  logic [CPUS-1:0]  w_d_req;
  logic [CPUS-1:0]  w_d_gnt;
  logic [CPUS-1:0]  w_i_gnt;
  logic [IW-1:0]    w_d_idx;
  logic [IW-1:0]    w_i_idx;
  logic             w_d_any;
  logic             w_i_any;
  logic [IW-1:0]    w_sel_port;
  logic [CPUS-1:0]  w_sel_gnt;
  arb_kind_t        w_sel_kind;
  word_t            w_sel_addr;
  word_t            w_sel_store;

  // A port asserting both dREN and dWEN counts as a data request (served as a write).
  assign w_d_req = bus.dREN | bus.dWEN;

  rr_picker #(.N(CPUS), .IW(IW)) u_pick_d (
    .i_req (w_d_req),
    .i_ptr (r_rr_ptr),
    .o_gnt (w_d_gnt),
    .o_idx (w_d_idx),
    .o_any (w_d_any)
  );

  rr_picker #(.N(CPUS), .IW(IW)) u_pick_i (
    .i_req (bus.iREN),
    .i_ptr (r_rr_ptr),
    .o_gnt (w_i_gnt),
    .o_idx (w_i_idx),
    .o_any (w_i_any)
  );

  // Winner selection: the data class wins whenever it has any request.
  always_comb begin
    w_sel_port  = w_i_idx;
    w_sel_gnt   = w_i_gnt;
    w_sel_kind  = IREAD;
    w_sel_addr  = bus.iaddr[w_i_idx];
    w_sel_store = 32'h0;
    if (w_d_any) begin
      w_sel_port  = w_d_idx;
      w_sel_gnt   = w_d_gnt;
      w_sel_kind  = bus.dWEN[w_d_idx] ? DWRITE : DREAD;
      w_sel_addr  = bus.daddr[w_d_idx];
      w_sel_store = bus.dstore[w_d_idx];
    end else begin
      w_sel_kind  = IREAD;
    end
  end

  // Arbiter FSM, RAM port drive and per-port response registers.
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      r_state    <= IDLE;
      r_kind     <= IREAD;
      r_port     <= '0;
      r_gnt      <= '0;
      r_rr_ptr   <= '0;
      r_hold     <= 1'b0;
      r_data     <= 32'h0;
      r_iwait    <= '1;
      r_dwait    <= '1;
      r_iload    <= '0;
      r_dload    <= '0;
      r_ramREN   <= 1'b0;
      r_ramWEN   <= 1'b0;
      r_ramaddr  <= 32'h0;
      r_ramstore <= 32'h0;
    end else begin
      // Wait lines idle high; only the RESP cycle pulls one low.
      r_iwait <= '1;
      r_dwait <= '1;
      case (r_state)
        IDLE: begin
          r_hold <= 1'b0;
          // r_hold skips the cycle right after a response, when the served
          // requester is still presenting its old (already answered) request.
          if (!r_hold && (w_d_any || w_i_any)) begin
            r_port     <= w_sel_port;
            r_gnt      <= w_sel_gnt;
            r_kind     <= w_sel_kind;
            r_ramaddr  <= w_sel_addr;
            r_ramstore <= w_sel_store;
            r_ramREN   <= (w_sel_kind != DWRITE);
            r_ramWEN   <= (w_sel_kind == DWRITE);
            r_state    <= REQ;
          end else begin
            r_state    <= IDLE;
          end
        end
        REQ: begin
          // ERROR is deliberately treated like BUSY: keep the request up and retry.
          if (bus.ramstate == ACCESS) begin
            if (r_kind != DWRITE) begin
              r_data <= bus.ramload;
            end else begin
              r_data <= r_data;
            end
            r_ramREN <= 1'b0;
            r_ramWEN <= 1'b0;
            r_state  <= RESP;
          end else begin
            r_state  <= REQ;
          end
        end
        RESP: begin
          case (r_kind)
            IREAD: begin
              r_iwait          <= ~r_gnt;
              r_iload[r_port]  <= r_data;
            end
            DREAD: begin
              r_dwait          <= ~r_gnt;
              r_dload[r_port]  <= r_data;
            end
            DWRITE: begin
              r_dwait          <= ~r_gnt;
            end
            default: begin
              r_dwait          <= '1;
            end
          endcase
          r_rr_ptr <= (int'(r_port) == CPUS - 1) ? '0 : r_port + IW'(1);
          r_hold   <= 1'b1;
          r_state  <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign bus.iwait    = r_iwait;
  assign bus.iload    = r_iload;
  assign bus.dwait    = r_dwait;
  assign bus.dload    = r_dload;
  assign bus.ramREN   = r_ramREN;
  assign bus.ramWEN   = r_ramWEN;
  assign bus.ramaddr  = r_ramaddr;
  assign bus.ramstore = r_ramstore;

endmodule

// File: tb/tb_mem_arbiter.sv
// Testbench for mem_arbiter: directed scenarios with literal expectations, then
// randomized requesters and RAM timing, all compared every cycle against a
// transaction-level reference model.
module tb_mem_arbiter;
  import cpu_types_pkg::*;

  localparam int CPUS = 2;
  localparam int K_IR = 0;
  localparam int K_DR = 1;
  localparam int K_DW = 2;

  logic CLK  = 1'b0;
  logic nRST = 1'b0;

  mem_arbiter_if #(.CPUS(CPUS)) bus();

  mem_arbiter #(.CPUS(CPUS)) dut (
    .CLK  (CLK),
    .nRST (nRST),
    .bus  (bus)
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_err    = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(negedge CLK);
  endtask

  // ---------------- reference model ----------------
  // One outstanding transaction: granted, waits for the first ACCESS after the
  // grant, answers on the following edge, then one dead cycle before the next grant.
  bit               m_valid = 1'b0;
  bit               m_busy, m_pulse, m_cool;
  int               m_rr, m_port, m_kind;
  word_t            m_data;
  logic [CPUS-1:0]  e_iwait, e_dwait;
  word_t [CPUS-1:0] e_iload, e_dload;
  logic             e_ren, e_wen;
  word_t            e_addr, e_store;

  function automatic int first_from(input int start, input logic [CPUS-1:0] req);
    for (int k = 0; k < CPUS; k++) begin
      if (req[(start + k) % CPUS]) return (start + k) % CPUS;
    end
    return -1;
  endfunction

  initial begin
    int p;
    forever begin
      @(posedge CLK);
      if (!nRST) begin
        m_valid = 1'b1; m_busy = 1'b0; m_pulse = 1'b0; m_cool = 1'b0; m_rr = 0;
        e_iwait = '1; e_dwait = '1; e_iload = '0; e_dload = '0;
        e_ren = 1'b0; e_wen = 1'b0; e_addr = 32'h0; e_store = 32'h0;
      end else if (m_valid) begin
        e_iwait = '1;
        e_dwait = '1;
        if (m_pulse) begin
          if (m_kind == K_IR) begin
            e_iwait[m_port] = 1'b0; e_iload[m_port] = m_data;
          end else begin
            e_dwait[m_port] = 1'b0;
            if (m_kind == K_DR) e_dload[m_port] = m_data;
          end
          m_rr = (m_port + 1) % CPUS;
          m_pulse = 1'b0; m_busy = 1'b0; m_cool = 1'b1;
        end else if (m_busy) begin
          if (bus.ramstate == ACCESS) begin
            if (m_kind != K_DW) m_data = bus.ramload;
            e_ren = 1'b0; e_wen = 1'b0; m_pulse = 1'b1;
          end
        end else if (m_cool) begin
          m_cool = 1'b0;
        end else begin
          p = first_from(m_rr, bus.dREN | bus.dWEN);
          if (p >= 0) begin
            m_busy = 1'b1; m_port = p;
            m_kind = bus.dWEN[p] ? K_DW : K_DR;
            e_addr = bus.daddr[p]; e_store = bus.dstore[p];
          end else begin
            p = first_from(m_rr, bus.iREN);
            if (p >= 0) begin
              m_busy = 1'b1; m_port = p; m_kind = K_IR;
              e_addr = bus.iaddr[p]; e_store = 32'h0;
            end
          end
          if (m_busy) begin
            e_ren = (m_kind != K_DW);
            e_wen = (m_kind == K_DW);
          end
        end
      end
    end
  end

  // Per-cycle comparison of every DUT output against the model.
  initial begin
    forever begin
      @(negedge CLK);
      if (m_valid) begin
        chk("m_iwait",    bus.iwait,    e_iwait);
        chk("m_dwait",    bus.dwait,    e_dwait);
        chk("m_iload",    bus.iload,    e_iload);
        chk("m_dload",    bus.dload,    e_dload);
        chk("m_ramREN",   bus.ramREN,   e_ren);
        chk("m_ramWEN",   bus.ramWEN,   e_wen);
        chk("m_ramaddr",  bus.ramaddr,  e_addr);
        chk("m_ramstore", bus.ramstore, e_store);
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    word_t           rr_exp [4];
    int              waitc;
    int              r;
    logic [CPUS-1:0] i_done, d_done;

    rr_exp = '{32'h2000, 32'h1000, 32'h2000, 32'h1000};
    bus.iREN = 2'b01; bus.iaddr = '0; bus.dREN = '0; bus.dWEN = '0;
    bus.daddr = '0; bus.dstore = '0; bus.ramload = 32'h0; bus.ramstate = FREE;

    // Reset held two cycles with a fetch pending.
    repeat (2) begin
      cyc();
      chk("rst_iwait",  bus.iwait,    2'b11);
      chk("rst_ramREN", bus.ramREN,   1'b0);
      chk("rst_iload0", bus.iload[0], 32'h0);
    end
    nRST = 1'b1; bus.iREN = 2'b00;
    cyc();

    // Single fetch, ACCESS on the first REQ cycle.
    bus.iREN = 2'b01; bus.iaddr[0] = 32'h40;
    cyc();
    chk("f_ramREN", bus.ramREN, 1'b1);
    chk("f_addr",   bus.ramaddr, 32'h40);
    chk("f_iwait0", bus.iwait, 2'b11);
    bus.ramstate = ACCESS; bus.ramload = 32'h8C010004;
    cyc();
    chk("f_ren_drop", bus.ramREN, 1'b0);
    chk("f_iwait1",   bus.iwait, 2'b11);
    bus.ramstate = FREE; bus.ramload = 32'h0;
    cyc();
    chk("f_pulse", bus.iwait, 2'b10);
    chk("f_iload", bus.iload[0], 32'h8C010004);
    cyc();
    chk("f_pulse_end", bus.iwait, 2'b11);
    chk("f_no_regrant", bus.ramREN, 1'b0);
    bus.iREN = 2'b00;
    cyc();
    chk("f_idle", bus.ramREN, 1'b0);

    // Data write beats a simultaneous fetch from the same port.
    bus.iREN = 2'b01; bus.iaddr[0] = 32'h200;
    bus.dWEN = 2'b01; bus.daddr[0] = 32'h100; bus.dstore[0] = 32'hDEADBEEF;
    bus.ramstate = ACCESS; bus.ramload = 32'h11112222;
    cyc();
    chk("p_wen",   bus.ramWEN, 1'b1);
    chk("p_ren",   bus.ramREN, 1'b0);
    chk("p_addr",  bus.ramaddr, 32'h100);
    chk("p_store", bus.ramstore, 32'hDEADBEEF);
    cyc();
    cyc();
    chk("p_dpulse", bus.dwait, 2'b10);
    chk("p_iwait",  bus.iwait, 2'b11);
    cyc();
    bus.dWEN = 2'b00;
    cyc();
    chk("p_fetch_ren",  bus.ramREN, 1'b1);
    chk("p_fetch_addr", bus.ramaddr, 32'h200);
    cyc();
    cyc();
    chk("p_ipulse", bus.iwait, 2'b10);
    chk("p_iload",  bus.iload[0], 32'h11112222);

    // Round-robin with both fetch requests held; last served was CPU0.
    bus.iREN = 2'b11; bus.iaddr[0] = 32'h1000; bus.iaddr[1] = 32'h2000;
    for (int t = 0; t < 4; t++) begin
      waitc = 0;
      while (bus.ramREN !== 1'b1 && waitc < 20) begin cyc(); waitc++; end
      chk("rr_grant_timeout", (waitc < 20), 1'b1);
      chk("rr_order", bus.ramaddr, rr_exp[t]);
      while (bus.ramREN === 1'b1 && waitc < 40) begin cyc(); waitc++; end
    end
    bus.iREN = 2'b00;
    repeat (4) cyc();

    // RAM latency: BUSY, ERROR, BUSY, then ACCESS on a CPU1 data read.
    bus.dREN = 2'b10; bus.daddr[1] = 32'h300; bus.ramstate = BUSY;
    cyc();
    chk("l_ren0", bus.ramREN, 1'b1);
    chk("l_addr", bus.ramaddr, 32'h300);
    bus.ramstate = BUSY;
    cyc();
    chk("l_ren1", bus.ramREN, 1'b1);
    bus.ramstate = ERROR;
    cyc();
    chk("l_ren2", bus.ramREN, 1'b1);
    bus.ramstate = BUSY;
    cyc();
    chk("l_ren3", bus.ramREN, 1'b1);
    chk("l_dwait_hold", bus.dwait, 2'b11);
    bus.ramstate = ACCESS; bus.ramload = 32'h12345678;
    cyc();
    chk("l_ren_drop", bus.ramREN, 1'b0);
    chk("l_dwait_hold2", bus.dwait, 2'b11);
    bus.ramstate = FREE;
    cyc();
    chk("l_pulse", bus.dwait, 2'b01);
    chk("l_dload", bus.dload[1], 32'h12345678);
    cyc();
    bus.dREN = 2'b00;
    cyc();

    // Reset in the middle of a write that the RAM keeps BUSY.
    bus.dWEN = 2'b01; bus.daddr[0] = 32'h400; bus.dstore[0] = 32'hCAFEF00D; bus.ramstate = BUSY;
    cyc();
    chk("r_wen", bus.ramWEN, 1'b1);
    nRST = 1'b0;
    cyc();
    chk("r_wen_drop", bus.ramWEN, 1'b0);
    chk("r_dwait",    bus.dwait, 2'b11);
    chk("r_addr_clr", bus.ramaddr, 32'h0);
    nRST = 1'b1;
    cyc();
    chk("r_resume_wen",  bus.ramWEN, 1'b1);
    chk("r_resume_addr", bus.ramaddr, 32'h400);
    chk("r_resume_wait", bus.dwait, 2'b11);
    bus.ramstate = ACCESS;
    cyc();
    bus.ramstate = FREE;
    cyc();
    chk("r_pulse", bus.dwait, 2'b10);
    cyc();
    bus.dWEN = 2'b00;
    cyc();

    // Randomized requesters and RAM timing; the model checks every cycle.
    i_done = '0; d_done = '0;
    for (int c = 0; c < 3000; c++) begin
      cyc();
      for (int p = 0; p < CPUS; p++) begin
        if (bus.iREN[p]) begin
          if (i_done[p]) begin
            bus.iREN[p] = ($urandom_range(0, 3) == 0);
            bus.iaddr[p] = $urandom;
            i_done[p] = 1'b0;
          end else if (bus.iwait[p] == 1'b0) begin
            i_done[p] = 1'b1;
          end else if ($urandom_range(0, 63) == 0) begin
            bus.iREN[p] = 1'b0;
          end
        end else if ($urandom_range(0, 3) == 0) begin
          bus.iREN[p] = 1'b1; bus.iaddr[p] = $urandom;
        end
        if (bus.dREN[p] || bus.dWEN[p]) begin
          if (d_done[p]) begin
            bus.dREN[p] = 1'b0; bus.dWEN[p] = 1'b0; d_done[p] = 1'b0;
          end else if (bus.dwait[p] == 1'b0) begin
            d_done[p] = 1'b1;
          end else if ($urandom_range(0, 63) == 0) begin
            bus.dREN[p] = 1'b0; bus.dWEN[p] = 1'b0;
          end
        end else if ($urandom_range(0, 3) == 0) begin
          r = $urandom_range(0, 2);
          bus.dREN[p] = (r != 1);
          bus.dWEN[p] = (r != 0);
          bus.daddr[p] = $urandom; bus.dstore[p] = $urandom;
        end
      end
      r = $urandom_range(0, 9);
      bus.ramstate = (r < 4) ? ACCESS : (r < 7) ? BUSY : (r < 9) ? FREE : ERROR;
      bus.ramload = $urandom;
      nRST = ($urandom_range(0, 299) != 0);
    end
    nRST = 1'b1;
    repeat (2) cyc();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
